// File: rtl/sprite_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_ctrl_pkg
//  Description : Shared scancodes, direction indices, PS2 decode states and
//                requester identifiers for the sprite movement controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_ctrl_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_UP  = 8'h75;
    localparam logic [7:0] SC_DN  = 8'h72;
    localparam logic [7:0] SC_LT  = 8'h6B;
    localparam logic [7:0] SC_RT  = 8'h74;

    // Request vectors are ordered {up, down, left, right}
    localparam int DIR_UP = 3;
    localparam int DIR_DN = 2;
    localparam int DIR_LT = 1;
    localparam int DIR_RT = 0;

    localparam logic SRC_BTN = 1'b0;
    localparam logic SRC_PS2 = 1'b1;

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_EXT    = 2'd1,
        P_BRK    = 2'd2,
        P_EXTBRK = 2'd3
    } ps2_state_t;

    function automatic logic [3:0] sc_dir_mask(input logic [7:0] sc);
        logic [3:0] m;
        m = 4'b0000;
        case (sc)
            SC_UP:   m[DIR_UP] = 1'b1;
            SC_DN:   m[DIR_DN] = 1'b1;
            SC_LT:   m[DIR_LT] = 1'b1;
            SC_RT:   m[DIR_RT] = 1'b1;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_move_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_move_ctrl_if
//  Description : Input requests and position outputs of the sprite controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_move_ctrl_if;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic       frame_tick;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       move_valid;
    logic       grant_src;

    modport master (
        output up, down, left, right, ps2_key_pressed, ps2_key_data, frame_tick,
        input  pos_x, pos_y, move_valid, grant_src
    );

    modport slave (
        input  up, down, left, right, ps2_key_pressed, ps2_key_data, frame_tick,
        output pos_x, pos_y, move_valid, grant_src
    );
endinterface
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Synchronises an active-low push-button and accepts a new
//                level only after DEB_CYCLES consecutive equal samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  wire logic clock,
    input  wire logic resetn,
    input  wire logic raw_n,
    output logic      level
);
    localparam int CW = $clog2(DEB_CYCLES) + 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_smp;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          w_lvl;

    assign w_lvl = ~r_s2;
    assign level = r_level;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_smp   <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_s1  <= raw_n;
            r_s2  <= r_s1;
            r_smp <= w_lvl;
            if (w_lvl != r_smp) begin
                r_cnt <= '0;
            end else if (r_cnt != CW'(DEB_CYCLES - 1)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_level <= r_smp;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/sprite_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_move_ctrl
//  Description : Arbitrates buttons and PS2 arrows onto a clamped sprite
//                position, updated at most once per frame_tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_move_ctrl
    import sprite_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int STEP       = 4,
    parameter int X_MAX      = 624,
    parameter int Y_MAX      = 464,
    parameter int INIT_X     = 312,
    parameter int INIT_Y     = 232
) (
    input  wire logic          clock,
    input  wire logic          resetn,
    sprite_move_ctrl_if.slave  bus
);
    logic [3:0] w_raw_n;
    logic [3:0] w_btn_req;

    assign w_raw_n = {bus.up, bus.down, bus.left, bus.right};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_deb
            button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clock  (clock),
                .resetn (resetn),
                .raw_n  (w_raw_n[gi]),
                .level  (w_btn_req[gi])
            );
        end
    endgenerate

    ps2_state_t r_state, w_state_nxt;
    logic [3:0] r_held, w_held_nxt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= P_IDLE;
            r_held  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_held  <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_held_nxt  = r_held;
        if (bus.ps2_key_pressed) begin
            case (r_state)
                P_IDLE: begin
                    if (bus.ps2_key_data == SC_EXT)      w_state_nxt = P_EXT;
                    else if (bus.ps2_key_data == SC_BRK) w_state_nxt = P_BRK;
                end
                P_EXT: begin
                    if (bus.ps2_key_data == SC_BRK) begin
                        w_state_nxt = P_EXTBRK;
                    end else begin
                        w_held_nxt  = r_held | sc_dir_mask(bus.ps2_key_data);
                        w_state_nxt = P_IDLE;
                    end
                end
                P_EXTBRK: begin
                    w_held_nxt  = r_held & ~sc_dir_mask(bus.ps2_key_data);
                    w_state_nxt = P_IDLE;
                end
                default: w_state_nxt = P_IDLE;
            endcase
        end
    end

    logic               r_rr;
    logic [9:0]         r_pos_x;
    logic [8:0]         r_pos_y;
    logic               r_move_valid;
    logic               r_grant_src;

    logic               w_btn_act, w_ps2_act, w_grant, w_gsrc;
    logic [3:0]         w_req;
    logic signed [10:0] w_dx, w_x_sum;
    logic signed [9:0]  w_dy, w_y_sum;
    logic [9:0]         w_x_nxt;
    logic [8:0]         w_y_nxt;

    // Arbitration sees the registered held flags, so a PS2 byte arriving
    // with frame_tick only takes effect on a later frame.
    always_comb begin
        w_btn_act = |w_btn_req;
        w_ps2_act = |r_held;
        w_grant   = w_btn_act | w_ps2_act;
        w_gsrc    = (w_btn_act && w_ps2_act) ? r_rr : w_ps2_act;
        w_req     = (w_gsrc == SRC_PS2) ? r_held : w_btn_req;

        w_dx = '0;
        if (w_req[DIR_RT] && !w_req[DIR_LT])      w_dx = 11'(STEP);
        else if (w_req[DIR_LT] && !w_req[DIR_RT]) w_dx = -11'(STEP);
        w_dy = '0;
        if (w_req[DIR_DN] && !w_req[DIR_UP])      w_dy = 10'(STEP);
        else if (w_req[DIR_UP] && !w_req[DIR_DN]) w_dy = -10'(STEP);

        w_x_sum = $signed({1'b0, r_pos_x}) + w_dx;
        w_y_sum = $signed({1'b0, r_pos_y}) + w_dy;

        if (w_x_sum < 0)                      w_x_nxt = '0;
        else if (w_x_sum > $signed(11'(X_MAX))) w_x_nxt = 10'(X_MAX);
        else                                  w_x_nxt = w_x_sum[9:0];

        if (w_y_sum < 0)                      w_y_nxt = '0;
        else if (w_y_sum > $signed(10'(Y_MAX))) w_y_nxt = 9'(Y_MAX);
        else                                  w_y_nxt = w_y_sum[8:0];
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rr         <= SRC_BTN;
            r_pos_x      <= 10'(INIT_X);
            r_pos_y      <= 9'(INIT_Y);
            r_move_valid <= 1'b0;
            r_grant_src  <= SRC_BTN;
        end else if (bus.frame_tick && w_grant) begin
            r_pos_x      <= w_x_nxt;
            r_pos_y      <= w_y_nxt;
            r_move_valid <= (w_x_nxt != r_pos_x) || (w_y_nxt != r_pos_y);
            r_grant_src  <= w_gsrc;
            r_rr         <= ~w_gsrc;
        end else begin
            r_move_valid <= 1'b0;
        end
    end

    assign bus.pos_x      = r_pos_x;
    assign bus.pos_y      = r_pos_y;
    assign bus.move_valid = r_move_valid;
    assign bus.grant_src  = r_grant_src;
endmodule
`default_nettype wire

// File: tb/tb_sprite_move_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_move_ctrl
//  Description : Directed self-checking bench for sprite_move_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_move_ctrl;
    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_err;

    sprite_move_ctrl_if bus ();

    sprite_move_ctrl #(
        .DEB_CYCLES (8),
        .STEP       (4),
        .X_MAX      (624),
        .Y_MAX      (464),
        .INIT_X     (312),
        .INIT_Y     (232)
    ) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic ftick();
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
    endtask

    task automatic ps2(input logic [7:0] b);
        bus.ps2_key_data    = b;
        bus.ps2_key_pressed = 1'b1;
        tick();
        bus.ps2_key_pressed = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int mv);
        chk({tag, ".x"}, int'(bus.pos_x), x);
        chk({tag, ".y"}, int'(bus.pos_y), y);
        chk({tag, ".mv"}, int'(bus.move_valid), mv);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        bus.up = 1'b1; bus.down = 1'b1; bus.left = 1'b1; bus.right = 1'b1;
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_key_data    = 8'h00;
        bus.frame_tick      = 1'b0;
        idle(2);
        resetn = 1'b1;
        chk_pos("reset", 312, 232, 0);
        chk("reset.gs", int'(bus.grant_src), 0);

        // Debounced button move, then a short glitch that must be rejected
        bus.right = 1'b0;
        idle(20);
        ftick();
        chk_pos("btn_right", 316, 232, 1);
        chk("btn_right.gs", int'(bus.grant_src), 0);
        tick();
        chk("mv_pulse", int'(bus.move_valid), 0);
        bus.right = 1'b1;
        idle(20);
        bus.right = 1'b0;
        idle(5);
        bus.right = 1'b1;
        idle(20);
        ftick();
        chk_pos("glitch", 316, 232, 0);

        // PS2 extended make and break
        ps2(8'hE0); ps2(8'h75);
        ftick();
        chk_pos("ps2_up", 316, 228, 1);
        chk("ps2_up.gs", int'(bus.grant_src), 1);
        ps2(8'hE0); ps2(8'hF0); ps2(8'h75);
        ftick();
        chk_pos("ps2_rel", 316, 228, 0);

        // Round robin: buttons first, then PS2, then buttons
        bus.left = 1'b0;
        ps2(8'hE0); ps2(8'h72);
        idle(20);
        ftick();
        chk_pos("rr1", 312, 228, 1);
        chk("rr1.gs", int'(bus.grant_src), 0);
        ftick();
        chk_pos("rr2", 312, 232, 1);
        chk("rr2.gs", int'(bus.grant_src), 1);
        ftick();
        chk_pos("rr3", 308, 232, 1);
        chk("rr3.gs", int'(bus.grant_src), 0);
        bus.left = 1'b1;
        ps2(8'hE0); ps2(8'hF0); ps2(8'h72);
        idle(20);
        ftick();
        chk_pos("none", 308, 232, 0);

        // Opposing PS2 directions cancel but still count as a grant
        ps2(8'hE0); ps2(8'h6B); ps2(8'hE0); ps2(8'h74);
        ftick();
        chk_pos("cancel", 308, 232, 0);
        chk("cancel.gs", int'(bus.grant_src), 1);
        ps2(8'hE0); ps2(8'hF0); ps2(8'h6B);
        ps2(8'hE0); ps2(8'hF0); ps2(8'h74);

        // Clamp at X_MAX and at 0
        bus.right = 1'b0;
        idle(20);
        repeat (78) ftick();
        chk_pos("to620", 620, 232, 1);
        ftick();
        chk_pos("hit624", 624, 232, 1);
        ftick();
        chk_pos("sat624", 624, 232, 0);
        chk("sat624.gs", int'(bus.grant_src), 0);
        bus.right = 1'b1;
        bus.left  = 1'b0;
        idle(20);
        repeat (155) ftick();
        chk_pos("to4", 4, 232, 1);
        ftick();
        chk_pos("hit0", 0, 232, 1);
        ftick();
        chk_pos("sat0", 0, 232, 0);
        bus.left = 1'b1;
        idle(20);

        // PS2 byte coinciding with frame_tick is not yet visible to arbitration
        ps2(8'hE0);
        bus.ps2_key_data    = 8'h75;
        bus.ps2_key_pressed = 1'b1;
        bus.frame_tick      = 1'b1;
        tick();
        bus.ps2_key_pressed = 1'b0;
        bus.frame_tick      = 1'b0;
        chk_pos("same_cyc", 0, 232, 0);
        ftick();
        chk_pos("same_next", 0, 228, 1);

        // Reset with up held and the decoder in P_EXT
        ps2(8'hE0);
        resetn = 1'b0;
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
        resetn = 1'b1;
        chk_pos("rst2", 312, 232, 0);
        chk("rst2.gs", int'(bus.grant_src), 0);
        ps2(8'h75);
        ftick();
        chk_pos("post_rst", 312, 232, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
